// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM states, bus constants and timing widths.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WACK,
        RDATA,
        RNACK,
        STOP
    } state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;

    // CLK_DIV is limited to 1023, so a 10-bit divider counter is enough.
    localparam int unsigned DIV_W = 10;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: fires every CLK_DIV cycles while enabled and
// steps the q0..q3 index; stall_i holds the final count (SCL stretching).
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       stall_i,
    output logic       tick_o,
    output logic [1:0] q_o
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       q_q, q_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST) && !stall_i;
        cnt_d  = cnt_q;
        q_d    = q_q;
        if (!en_i) begin
            cnt_d = '0;
            q_d   = '0;
        end else if (cnt_q == LAST) begin
            if (!stall_i) begin
                cnt_d = '0;
                q_d   = q_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master (address + one write or read byte).
// Optional: define I2C_MASTER_CLK_STRETCH_EN to honour slave SCL stretching.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    state_e     state_q, state_d;
    logic [7:0] addr_rw_q, wdata_q, rdata_q;
    logic [2:0] bit_q;
    logic       ack_err_q, done_q;
    logic       en, stall, tick, bit_end, sample, accept, shift_state;
    logic [1:0] q;

    assign en          = (state_q != IDLE);
    assign accept      = start && (state_q == IDLE) && !done_q;
    assign bit_end     = tick && (q == 2'd3);
    assign sample      = tick && (q == 2'd1);
    assign shift_state = (state_q == ADDR) || (state_q == WDATA) || (state_q == RDATA);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    assign stall = (q == 2'd1) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .stall_i (stall),
        .tick_o  (tick),
        .q_o     (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = START;
            START:    if (bit_end) state_d = ADDR;
            ADDR:     if (bit_end && bit_q == 3'd7) state_d = ADDR_ACK;
            // ack_err_q was already updated at the q1 sample of this bit
            ADDR_ACK: if (bit_end) begin
                          if (ack_err_q)                      state_d = STOP;
                          else if (addr_rw_q[0] == I2C_READ)  state_d = RDATA;
                          else                                state_d = WDATA;
                      end
            WDATA:    if (bit_end && bit_q == 3'd7) state_d = WACK;
            WACK:     if (bit_end) state_d = STOP;
            RDATA:    if (bit_end && bit_q == 3'd7) state_d = RNACK;
            RNACK:    if (bit_end) state_d = STOP;
            STOP:     if (bit_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            START: begin
                scl_o = (q != 2'd3);
                sda_o = (q == 2'd0);
            end
            STOP: begin
                scl_o = (q != 2'd0);
                sda_o = (q == 2'd3);
            end
            ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK: begin
                scl_o = (q == 2'd1) || (q == 2'd2);
                if (state_q == ADDR)       sda_o = addr_rw_q[~bit_q];
                else if (state_q == WDATA) sda_o = wdata_q[~bit_q];
                else if (state_q == RNACK) sda_o = I2C_NACK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_rw_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bit_q     <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && bit_end;
            if (accept) begin
                addr_rw_q <= {addr, rw};
                wdata_q   <= wdata;
                bit_q     <= '0;
                ack_err_q <= 1'b0;
            end else begin
                if (bit_end && shift_state) bit_q <= bit_q + 3'd1;
                if (sample) begin
                    if ((state_q == ADDR_ACK || state_q == WACK) && sda_i == I2C_NACK)
                        ack_err_q <= 1'b1;
                    if (state_q == RDATA)
                        rdata_q <= {rdata_q[6:0], sda_i};
                end
            end
        end
    end

    assign busy    = en || done_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master with a bus-level slave model at address 0x42.
// The stretch scenario runs only when I2C_MASTER_CLK_STRETCH_EN is defined.
module tb_i2c_master;

    localparam int unsigned CLK_DIV    = 5;
    localparam logic [6:0]  SLAVE_ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl_o, sda_o;
    logic       scl_bus, sda_bus;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl_o   (scl_o),
        .sda_o   (sda_o),
        .scl_i   (scl_bus),
        .sda_i   (sda_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [7:0] rbyte = '0;
    logic       ack_wdata = 1'b1;
    logic       stretch_en = 1'b0;
    logic       sl_sda = 1'b1, sl_active = 1'b0, sl_match = 1'b0, sl_rd = 1'b0, sl_ackph = 1'b0;
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    logic [3:0] sl_bitn = '0;
    logic [7:0] sl_shreg = '0;
    int         sl_byte = 0;
    int         st_cnt = 0;
    logic [7:0] log_addr = '0, log_data = '0;
    logic       log_mack = 1'b0, stop_seen = 1'b0;
    logic       hold;

    assign hold    = stretch_en && sl_ackph && (st_cnt < 41);
    assign scl_bus = scl_o & ~hold;
    assign sda_bus = sda_o & sl_sda;

    always @(posedge clk) begin
        if (hold && scl_o)  st_cnt <= st_cnt + 1;
        else if (!sl_ackph) st_cnt <= 0;
    end

    always @(posedge clk) begin
        scl_prev <= scl_bus;
        sda_prev <= sda_bus;
        if (scl_prev && scl_bus && sda_prev && !sda_bus) begin
            sl_active <= 1'b1;
            sl_bitn   <= '0;
            sl_byte   <= 0;
            sl_sda    <= 1'b1;
            sl_ackph  <= 1'b0;
            stop_seen <= 1'b0;
        end else if (scl_prev && scl_bus && !sda_prev && sda_bus) begin
            stop_seen <= 1'b1;
            sl_active <= 1'b0;
            sl_sda    <= 1'b1;
        end else if (sl_active && !scl_prev && scl_bus) begin
            if (sl_bitn < 4'd8) begin
                sl_shreg <= {sl_shreg[6:0], sda_bus};
                sl_bitn  <= sl_bitn + 4'd1;
            end else begin
                sl_bitn  <= 4'd9;
                sl_ackph <= 1'b0;
                if (sl_byte == 1 && sl_rd) log_mack <= sda_bus;
            end
        end else if (sl_active && scl_prev && !scl_bus) begin
            if (sl_bitn == 4'd8) begin
                if (sl_byte == 0) begin
                    log_addr <= sl_shreg;
                    sl_match <= (sl_shreg[7:1] == SLAVE_ADDR);
                    sl_rd    <= sl_shreg[0];
                    sl_sda   <= (sl_shreg[7:1] != SLAVE_ADDR);
                    sl_ackph <= 1'b1;
                end else if (!sl_rd) begin
                    log_data <= sl_shreg;
                    sl_sda   <= !(sl_match && ack_wdata);
                end else begin
                    sl_sda <= 1'b1;
                end
            end else if (sl_bitn == 4'd9) begin
                sl_bitn <= '0;
                sl_byte <= sl_byte + 1;
                sl_sda  <= (sl_byte == 0 && sl_rd && sl_match) ? rbyte[7] : 1'b1;
            end else if (sl_byte == 1 && sl_rd && sl_match) begin
                sl_sda <= rbyte[7 - int'(sl_bitn)];
            end else begin
                sl_sda <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         acc;
        int         lat;
        logic       aerr;
        logic [7:0] rd;
        logic [7:0] ab;
        logic [7:0] db;
        logic       chk_d;
        logic       chk_m;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rdata = '0;
    int         issued = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.acc, e.lat);
                check("ack_err", ack_err, e.aerr);
                check("rdata", rdata, e.rd);
                check("addr_byte_on_bus", log_addr, e.ab);
                check("stop_on_bus", stop_seen, 1'b1);
                if (e.chk_d) check("data_byte_on_bus", log_data, e.db);
                if (e.chk_m) check("master_nack", log_mack, 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w,
                         input logic [7:0] rb, input logic aw, input int extra);
        exp_t e;
        logic nack_a;
        @(negedge clk);
        nack_a  = (a != SLAVE_ADDR);
        if (r && !nack_a) model_rdata = rb;
        e.aerr  = nack_a || (!r && !aw);
        e.rd    = model_rdata;
        e.lat   = 4 * CLK_DIV * (nack_a ? 11 : 20) + extra;
        e.ab    = {a, r};
        e.db    = w;
        e.chk_d = !r && !nack_a;
        e.chk_m = r && !nack_a;
        e.acc   = cyc + 1;
        rbyte     = rb;
        ack_wdata = aw;
        addr  = a;
        rw    = r;
        wdata = w;
        start = 1'b1;
        sb.push_back(e);
        issued++;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL timeout busy still high after %0d cycles", budget);
        end
    endtask

    task automatic run(input logic [6:0] a, input logic r, input logic [7:0] w,
                       input logic [7:0] rb, input logic aw, input int extra);
        issue(a, r, w, rb, aw, extra);
        wait_idle(1000);
    endtask

    initial begin
        int acc;
        int n;
        repeat (3) @(negedge clk);
        check("rst_scl", scl_o, 1'b1);
        check("rst_sda", sda_o, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(7'h42, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
        run(7'h42, 1'b1, 8'h00, 8'h3C, 1'b1, 0);
        run(7'h11, 1'b0, 8'h5A, 8'h00, 1'b1, 0);
        run(7'h11, 1'b1, 8'h00, 8'hFF, 1'b1, 0);

        for (int i = 0; i < 10; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE_ADDR;
            run(a, 1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 0);
        end

        // start while busy must be ignored
        issue(7'h42, 1'b0, 8'h5A, 8'h00, 1'b1, 0);
        repeat (50) @(negedge clk);
        addr  = 7'h11;
        rw    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // start coincident with done must also be ignored
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_with_done_ignored", busy, 1'b0);

        // reset in the middle of a write
        issue(7'h42, 1'b0, 8'h77, 8'h00, 1'b1, 0);
        acc = cyc;
        while (cyc < acc + 150) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_scl", scl_o, 1'b1);
        check("midrst_sda", sda_o, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        sb.delete();
        issued--;
        model_rdata = '0;
        @(negedge clk);
        check("midrst_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run(7'h42, 1'b0, 8'hC3, 8'h00, 1'b1, 0);

`ifdef I2C_MASTER_CLK_STRETCH_EN
        stretch_en = 1'b1;
        run(7'h42, 1'b0, 8'hA5, 8'h00, 1'b1, 37);
        stretch_en = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("done_pulse_count", done_cnt, issued);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
